// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: one host request becomes a SETUP / STROBE / HOLD
// bus cycle with registered, glitch-free _OE/_WE and a tri-stated data bus.
module sram_ctrl #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 16,
    parameter int SETUP  = 1,
    parameter int STROBE = 2,
    parameter int HOLD   = 1
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              req,
    input  logic              rw,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DWIDTH-1:0] rdata,
    output logic              _OE,
    output logic              _WE,
    output logic [AWIDTH-1:0] A,
    inout  wire  [DWIDTH-1:0] D
);

    // state    | meaning
    // S_IDLE   | waiting for req; bus released, strobes high
    // S_SETUP  | address (and write data) settling before the strobe
    // S_STROBE | _OE (read) or _WE (write) held low
    // S_HOLD   | strobe released, address/data held; ack in last cycle
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    // Phase counter counts down to zero; the load value is length-1.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD - 1);

    state_t            state;
    state_t            state_d;
    logic [3:0]        cnt;
    logic [3:0]        cnt_d;
    logic              rw_q;
    logic [DWIDTH-1:0] wdata_q;
    logic              d_en;
    logic              d_en_d;
    logic              oe_n_d;
    logic              we_n_d;
    logic              ack_d;
    logic              accept;
    logic              last_strobe;

    assign accept      = (state == S_IDLE) && req;
    assign last_strobe = (state == S_STROBE) && (cnt == 4'd0);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ack_d   = 1'b0;
        d_en_d  = d_en;

        case (state)
            S_IDLE: begin
                if (req) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt == 4'd0) begin
                    state_d = S_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt == 4'd0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt == 4'd0) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Strobes and ack are decoded from the next state so the flops
        // present them aligned with the state they belong to.
        if (state_d == S_STROBE) begin
            oe_n_d = rw_q;
            we_n_d = ~rw_q;
        end
        ack_d = (state_d == S_HOLD) && (cnt_d == 4'd0);

        if (accept) begin
            d_en_d = rw;
        end else if (state_d == S_IDLE) begin
            d_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            _OE   <= 1'b1;
            _WE   <= 1'b1;
            ack   <= 1'b0;
            d_en  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            _OE   <= oe_n_d;
            _WE   <= we_n_d;
            ack   <= ack_d;
            d_en  <= d_en_d;
        end
    end

    // Request fields are captured only on acceptance; host activity while
    // busy cannot reach the bus.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rw_q    <= 1'b0;
            A       <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            if (accept) begin
                rw_q    <= rw;
                A       <= addr;
                wdata_q <= wdata;
            end
            if (last_strobe && !rw_q) begin
                rdata <= D;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign D    = d_en ? wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: default-timing and stretched-timing instances, each on a
// behavioural SRAM; expected waveforms come from the phase-length arithmetic.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        req1, req2, rw;
    logic [15:0] addr;
    logic [7:0]  wdata;

    logic        busy1, ack1, oe1, we1;
    logic [7:0]  rdata1;
    logic [15:0] a1;
    tri1  [7:0]  d1;
    logic        busy2, ack2, oe2, we2;
    logic [7:0]  rdata2;
    logic [15:0] a2;
    tri1  [7:0]  d2;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram1 [0:65535];
    logic [7:0]  ram2 [0:65535];
    logic [7:0]  ref1 [0:7];
    logic [7:0]  ref2 [0:7];

    logic [3:0]  obs_ctl [0:15];
    logic [15:0] obs_a   [0:15];
    logic [7:0]  obs_d   [0:15];
    logic [7:0]  obs_rd  [0:15];

    always #5 clk = ~clk;

    sram_ctrl u_dut1 (
        .clk(clk), ._reset(reset_b), .req(req1), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy1), .ack(ack1), .rdata(rdata1), ._OE(oe1), ._WE(we1), .A(a1), .D(d1)
    );

    sram_ctrl #(.SETUP(2), .STROBE(3), .HOLD(2)) u_dut2 (
        .clk(clk), ._reset(reset_b), .req(req2), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy2), .ack(ack2), .rdata(rdata2), ._OE(oe2), ._WE(we2), .A(a2), .D(d2)
    );

    // SRAM models: drive while _OE low, store on the rising edge of _WE.
    assign d1 = (!oe1) ? ram1[a1] : 8'hzz;
    assign d2 = (!oe2) ? ram2[a2] : 8'hzz;

    always @(posedge we1) if (reset_b === 1'b1) ram1[a1] = d1;
    always @(posedge we2) if (reset_b === 1'b1) ram2[a2] = d2;

    always @(negedge clk) begin
        if (reset_b === 1'b1) begin
            checks++;
            if (!oe1 && !we1) begin
                errors++;
                $display("FAIL oe_we_overlap dut1: _OE=%b _WE=%b, required never both 0", oe1, we1);
            end
            checks++;
            if (!oe2 && !we2) begin
                errors++;
                $display("FAIL oe_we_overlap dut2: _OE=%b _WE=%b, required never both 0", oe2, we2);
            end
        end
    end

    // Issue one request and record n+1 cycles after the accepting edge;
    // host inputs are scrambled while the operation runs.
    task automatic capture(input bit which, input logic rw_i, input logic [15:0] a_i,
                           input logic [7:0] d_i, input int n);
        @(negedge clk);
        if (which) req2 = 1'b1; else req1 = 1'b1;
        rw = rw_i; addr = a_i; wdata = d_i;
        @(posedge clk);
        #1;
        req1 = 1'b0; req2 = 1'b0;
        rw = ~rw_i; addr = 16'($urandom); wdata = 8'($urandom);
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            obs_ctl[c] = which ? {busy2, ack2, oe2, we2} : {busy1, ack1, oe1, we1};
            obs_a[c]   = which ? a2 : a1;
            obs_d[c]   = which ? d2 : d1;
            obs_rd[c]  = which ? rdata2 : rdata1;
        end
    endtask

    task automatic test_reset();
        reset_b = 1'b0; req1 = 1'b0; req2 = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            logic [3:0]  ctl;
            logic [15:0] a;
            logic [7:0]  d, rd;
            ctl = w ? {busy2, ack2, oe2, we2} : {busy1, ack1, oe1, we1};
            a   = w ? a2 : a1;
            d   = w ? d2 : d1;
            rd  = w ? rdata2 : rdata1;
            checks++;
            if (ctl !== 4'b0011) begin
                errors++; $display("FAIL reset_ctl dut%0d: got %b want 0011", w + 1, ctl);
            end
            checks++;
            if (a !== 16'h0) begin
                errors++; $display("FAIL reset_addr dut%0d: got %h want 0000", w + 1, a);
            end
            checks++;
            if (d !== 8'hFF) begin
                errors++; $display("FAIL reset_bus_released dut%0d: got %h want ff (pulled)", w + 1, d);
            end
            checks++;
            if (rd !== 8'h00) begin
                errors++; $display("FAIL reset_rdata dut%0d: got %h want 00", w + 1, rd);
            end
        end
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    task automatic test_default_write_read();
        capture(1'b0, 1'b1, 16'h1234, 8'hA5, 4);
        for (int c = 1; c <= 5; c++) begin
            logic [3:0] want;
            want = {c <= 4, c == 4, 1'b1, !(c == 2 || c == 3)};
            checks++;
            if (obs_ctl[c] !== want) begin
                errors++; $display("FAIL dflt_write_ctl c%0d: got %b want %b", c, obs_ctl[c], want);
            end
            if (c <= 4) begin
                checks++;
                if (obs_a[c] !== 16'h1234) begin
                    errors++; $display("FAIL dflt_write_addr c%0d: got %h want 1234", c, obs_a[c]);
                end
            end
            checks++;
            if (obs_d[c] !== ((c <= 4) ? 8'hA5 : 8'hFF)) begin
                errors++; $display("FAIL dflt_write_data c%0d: got %h want %h", c, obs_d[c], (c <= 4) ? 8'hA5 : 8'hFF);
            end
        end
        checks++;
        if (ram1[16'h1234] !== 8'hA5) begin
            errors++; $display("FAIL dflt_write_ram: got %h want a5", ram1[16'h1234]);
        end

        capture(1'b0, 1'b0, 16'h1234, 8'h11, 4);
        for (int c = 1; c <= 5; c++) begin
            logic [3:0] want;
            want = {c <= 4, c == 4, !(c == 2 || c == 3), 1'b1};
            checks++;
            if (obs_ctl[c] !== want) begin
                errors++; $display("FAIL dflt_read_ctl c%0d: got %b want %b", c, obs_ctl[c], want);
            end
            if (c != 2 && c != 3) begin
                checks++;
                if (obs_d[c] !== 8'hFF) begin
                    errors++; $display("FAIL dflt_read_bus_released c%0d: got %h want ff", c, obs_d[c]);
                end
            end
        end
        checks++;
        if (obs_rd[4] !== 8'hA5) begin
            errors++; $display("FAIL dflt_read_rdata: got %h want a5", obs_rd[4]);
        end
    endtask

    task automatic test_stretched_timing();
        capture(1'b1, 1'b1, 16'h0ABC, 8'h5E, 7);
        for (int c = 1; c <= 8; c++) begin
            logic [3:0] want;
            want = {c <= 7, c == 7, 1'b1, !(c >= 3 && c <= 5)};
            checks++;
            if (obs_ctl[c] !== want) begin
                errors++; $display("FAIL stretch_write_ctl c%0d: got %b want %b", c, obs_ctl[c], want);
            end
        end
        checks++;
        if (ram2[16'h0ABC] !== 8'h5E) begin
            errors++; $display("FAIL stretch_write_ram: got %h want 5e", ram2[16'h0ABC]);
        end
        capture(1'b1, 1'b0, 16'h0ABC, 8'h00, 7);
        for (int c = 1; c <= 8; c++) begin
            logic [3:0] want;
            want = {c <= 7, c == 7, !(c >= 3 && c <= 5), 1'b1};
            checks++;
            if (obs_ctl[c] !== want) begin
                errors++; $display("FAIL stretch_read_ctl c%0d: got %b want %b", c, obs_ctl[c], want);
            end
        end
        checks++;
        if (obs_rd[7] !== 8'h5E) begin
            errors++; $display("FAIL stretch_read_rdata: got %h want 5e", obs_rd[7]);
        end
    endtask

    task automatic test_back_to_back();
        logic b[1:11];
        logic k[1:11];
        logic [7:0] rd9;
        @(negedge clk);
        req1 = 1'b1; rw = 1'b1; addr = 16'h0001; wdata = 8'h3C;
        @(posedge clk);
        #1;
        rw = 1'b0; wdata = 8'h00;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            b[c] = busy1; k[c] = ack1;
            if (c == 9) rd9 = rdata1;
            if (c == 6) req1 = 1'b0;
        end
        for (int c = 1; c <= 11; c++) begin
            checks++;
            if (b[c] !== ((c <= 4) || (c >= 6 && c <= 9))) begin
                errors++; $display("FAIL b2b_busy c%0d: got %b want %b", c, b[c], (c <= 4) || (c >= 6 && c <= 9));
            end
            checks++;
            if (k[c] !== (c == 4 || c == 9)) begin
                errors++; $display("FAIL b2b_ack c%0d: got %b want %b", c, k[c], c == 4 || c == 9);
            end
        end
        checks++;
        if (rd9 !== 8'h3C) begin
            errors++; $display("FAIL b2b_read_data: got %h want 3c", rd9);
        end
    endtask

    task automatic test_random();
        logic [7:0] last1, last2;
        last1 = 8'h3C;
        last2 = 8'h5E;
        for (int i = 0; i < 8; i++) begin
            ref1[i] = 8'($urandom_range(0, 254));
            ref2[i] = 8'($urandom_range(0, 254));
            ram1[16'h0100 + 16'(i)] = ref1[i];
            ram2[16'h0100 + 16'(i)] = ref2[i];
        end
        for (int op = 0; op < 40; op++) begin
            bit          which;
            logic        rwi;
            int          idx, s, t, n;
            logic [15:0] ai;
            logic [7:0]  wd, want_rd;
            which = 1'($urandom_range(0, 1));
            rwi   = 1'($urandom_range(0, 1));
            idx   = $urandom_range(0, 7);
            ai    = 16'h0100 + 16'(idx);
            wd    = 8'($urandom_range(0, 254));
            s = which ? 2 : 1;
            t = which ? 3 : 2;
            n = s + t + (which ? 2 : 1);
            if (rwi) begin
                want_rd = which ? last2 : last1;
                if (which) ref2[idx] = wd; else ref1[idx] = wd;
            end else begin
                want_rd = which ? ref2[idx] : ref1[idx];
                if (which) last2 = want_rd; else last1 = want_rd;
            end
            capture(which, rwi, ai, wd, n);
            for (int c = 1; c <= n + 1; c++) begin
                logic       strb;
                logic [3:0] want;
                strb = (c > s) && (c <= s + t);
                want = {c <= n, c == n, !(strb && !rwi), !(strb && rwi)};
                checks++;
                if (obs_ctl[c] !== want) begin
                    errors++; $display("FAIL rand_ctl op%0d dut%0d c%0d: got %b want %b", op, which + 1, c, obs_ctl[c], want);
                end
                if (c <= n) begin
                    checks++;
                    if (obs_a[c] !== ai) begin
                        errors++; $display("FAIL rand_addr op%0d c%0d: got %h want %h", op, c, obs_a[c], ai);
                    end
                end
                if (rwi && c <= n) begin
                    checks++;
                    if (obs_d[c] !== wd) begin
                        errors++; $display("FAIL rand_wdata op%0d c%0d: got %h want %h", op, c, obs_d[c], wd);
                    end
                end else if (!strb) begin
                    checks++;
                    if (obs_d[c] !== 8'hFF) begin
                        errors++; $display("FAIL rand_bus_released op%0d c%0d: got %h want ff", op, c, obs_d[c]);
                    end
                end
            end
            checks++;
            if (obs_rd[n] !== want_rd) begin
                errors++; $display("FAIL rand_rdata op%0d dut%0d rw=%b: got %h want %h", op, which + 1, rwi, obs_rd[n], want_rd);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit found;
        capture(1'b0, 1'b0, 16'h1234, 8'h00, 4);
        @(negedge clk);
        req1 = 1'b1; rw = 1'b1; addr = 16'h0040; wdata = 8'h77;
        @(posedge clk);
        #1;
        req1 = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (we1 === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL reset_mid_no_strobe: _WE never low within 10 cycles, required low");
        end
        #2;
        reset_b = 1'b0;
        #1;
        checks++;
        if ({busy1, ack1, oe1, we1} !== 4'b0011) begin
            errors++; $display("FAIL reset_mid_ctl: got %b want 0011", {busy1, ack1, oe1, we1});
        end
        checks++;
        if (d1 !== 8'hFF) begin
            errors++; $display("FAIL reset_mid_bus: got %h want ff (released)", d1);
        end
        checks++;
        if (rdata1 !== 8'h00) begin
            errors++; $display("FAIL reset_mid_rdata: got %h want 00", rdata1);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (ack1 !== 1'b0 || ack2 !== 1'b0) begin
                errors++; $display("FAIL reset_mid_ack: got %b%b want 00", ack1, ack2);
            end
        end
    endtask

    task automatic test_first_req_after_reset();
        @(negedge clk);
        reset_b = 1'b1; req1 = 1'b1; rw = 1'b0; addr = 16'h1234; wdata = 8'h00;
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++; $display("FAIL post_reset_accept: busy got %b want 1", busy1);
        end
        req1 = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if ({busy1, ack1} !== {c <= 4, c == 4}) begin
                errors++; $display("FAIL post_reset_timing c%0d: got %b%b want %b%b", c, busy1, ack1, c <= 4, c == 4);
            end
            if (c == 4) begin
                checks++;
                if (rdata1 !== 8'hA5) begin
                    errors++; $display("FAIL post_reset_rdata: got %h want a5", rdata1);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_write_read();
        test_stretched_timing();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        test_first_req_after_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter DWIDTH, default 8, data width in bits.
REQ-002 Parameter AWIDTH, default 16, address width in bits.
REQ-003 Parameter SETUP, default 1, address/data setup cycles before strobe; legal range 1..15.
REQ-004 Parameter STROBE, default 2, cycles _OE or _WE is held low; legal range 1..15.
REQ-005 Parameter HOLD, default 1, cycles after strobe release before the cycle completes; legal range 1..15.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 _reset  input  1  reset, asynchronous and active-low.
REQ-008 req  input  1  host request; sampled only in IDLE.
REQ-009 rw  input  1  1 = write, 0 = read; sampled with req.
REQ-010 addr  input  AWIDTH  host address; sampled with req.
REQ-011 wdata  input  DWIDTH  host write data; sampled with req.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 ack  output  1  one-cycle completion pulse.
REQ-014 rdata  output  DWIDTH  last read data; holds value until the next read completes.
REQ-015 _OE  output  1  SRAM output enable, active-low.
REQ-016 _WE  output  1  SRAM write enable, active-low.
REQ-017 A  output  AWIDTH  SRAM address.
REQ-018 D  inout  DWIDTH  SRAM data bus; driven only during write cycles, high-Z otherwise.

Function
REQ-019 The state machine SHALL have states IDLE, SETUP, STROBE and HOLD, and a 4-bit phase counter.
REQ-020 In IDLE with req=1, the block SHALL latch rw, addr and wdata, and enter SETUP on the next edge; req=0 keeps it in IDLE.
REQ-021 SETUP SHALL last exactly SETUP cycles, STROBE exactly STROBE cycles and HOLD exactly HOLD cycles, then the block SHALL return to IDLE.
REQ-022 A SHALL equal the latched address from SETUP through HOLD inclusive, and SHALL be stable for that whole span.
REQ-023 Write: D SHALL be driven with the latched wdata in SETUP, STROBE and HOLD; _WE SHALL be low only in STROBE; _OE SHALL stay high.
REQ-024 Read: D SHALL be high-Z throughout; _OE SHALL be low only in STROBE; _WE SHALL stay high.
REQ-025 Read: rdata SHALL capture D on the clock edge that ends the last STROBE cycle.
REQ-026 _OE and _WE SHALL never be low at the same time, and D SHALL never be driven while _OE is low.
REQ-027 _OE and _WE SHALL be driven from registers so that they are glitch-free.
REQ-028 ack SHALL be high for exactly the last HOLD cycle; busy SHALL fall on the same edge that ack falls.
REQ-029 Total latency from the accepting edge to the ack cycle SHALL be SETUP+STROBE+HOLD cycles (4 cycles at defaults).
REQ-030 Back-to-back operation: a req held high SHALL be accepted on the first IDLE cycle, so there is one IDLE cycle between consecutive operations.
REQ-031 Changes on req, rw, addr or wdata while busy=1 SHALL be ignored and SHALL not alter the operation in progress.
REQ-032 If a read captures all-X or Z data, rdata SHALL take that value unchanged; no substitution is made.

Reset
REQ-033 _reset=0 SHALL immediately force the following, without waiting for clk: state IDLE, counter 0, busy=0, ack=0, _OE=1, _WE=1, A=0, D high-Z, rdata=0.
REQ-034 Reset asserted mid-operation SHALL abort the cycle; a write aborted in STROBE SHALL release _WE immediately, and the content of the target location is then undefined.
REQ-035 After _reset rises, the first request SHALL be accepted on the first rising clk edge at which req=1.

Verification
REQ-036 Write at defaults, addr=0x1234, wdata=0xA5 -> A=0x1234 for 4 cycles; D=0xA5 for 4 cycles; _WE low in cycles 2-3; ack in cycle 4; a RAM model then holds 0xA5 at 0x1234.
REQ-037 Read of 0x1234 after that write -> _OE low in cycles 2-3; D undriven by the controller; rdata=0xA5 in the ack cycle; busy low the next cycle.
REQ-038 req held high with alternating write 0x0001=0x3C and read 0x0001 -> exactly one IDLE cycle between operations; read returns 0x3C; the _OE/_WE overlap checker never fires.
REQ-039 Assert _reset during STROBE of a write -> on the same time step _WE=1, D=Z, busy=0, rdata=0; no ack pulse.
REQ-040 SETUP=2, STROBE=3, HOLD=2 -> ack arrives 7 cycles after acceptance; the strobe is 3 cycles wide.
REQ-041 Change addr and wdata while busy=1 -> A and D keep the latched values until the operation completes.
